// File: rtl/router_cfg_ctrl.sv
// router_cfg_ctrl: boots the router config registers, then arbitrates two requesters onto HBUS
module router_cfg_ctrl #(
  parameter logic [7:0]  BOOT_MAXPKT = 8'd63,
  parameter logic [7:0]  BOOT_ENABLE = 8'd1,
  parameter logic [15:0] ADDR_MAXPKT = 16'h1000,
  parameter logic [15:0] ADDR_ENABLE = 16'h1001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [7:0]  rsp0_rdata,
  output logic        rsp1_valid,
  output logic [7:0]  rsp1_rdata,
  output logic [15:0] haddr,
  output logic [7:0]  hdata_out,
  output logic        hdata_oe,
  input  logic [7:0]  hdata_in,
  output logic        hen,
  output logic        hwr_rd,
  output logic        boot_done
);
  localparam logic [2:0] BOOT0 = 3'd0;
  localparam logic [2:0] BOOT1 = 3'd1;
  localparam logic [2:0] IDLE  = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RD    = 3'd4;
  localparam logic [2:0] RDCAP = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        started_q;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        hen_q, hen_d;
  logic        hwr_q, hwr_d;
  logic        oe_q, oe_d;
  logic        rsp_q, rsp_d;
  logic        done_q, done_d;
  logic [15:0] haddr_q, haddr_d;
  logic [7:0]  hdata_q, hdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        gnt0, gnt1, acc, sel_wr;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  // grant in IDLE: a lone valid wins, a tie goes to whoever was not granted last
  always_comb begin
    gnt0      = (state_q == IDLE) & req0_valid & (~req1_valid | last_q);
    gnt1      = (state_q == IDLE) & req1_valid & (~req0_valid | ~last_q);
    acc       = gnt0 | gnt1;
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  end

  // next state and next bus outputs; bus outputs are registered so reset clears them at once
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    hen_d   = 1'b0;
    hwr_d   = 1'b0;
    oe_d    = 1'b0;
    rsp_d   = 1'b0;
    done_d  = done_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    rdata_d = rdata_q;
    case (state_q)
      BOOT0: begin
        hen_d   = 1'b1;
        hwr_d   = 1'b1;
        oe_d    = 1'b1;
        haddr_d = started_q ? ADDR_ENABLE : ADDR_MAXPKT;
        hdata_d = started_q ? BOOT_ENABLE : BOOT_MAXPKT;
        state_d = started_q ? BOOT1 : BOOT0;
      end
      BOOT1: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      IDLE: begin
        if (acc) begin
          id_d    = gnt1;
          last_d  = gnt1;
          hen_d   = 1'b1;
          hwr_d   = sel_wr;
          oe_d    = sel_wr;
          haddr_d = sel_addr;
          hdata_d = sel_wr ? sel_wdata : hdata_q;
          state_d = sel_wr ? WR : RD;
        end
      end
      WR: begin
        state_d = IDLE;
        rsp_d   = 1'b1;
        rdata_d = 8'h00;
      end
      RD: state_d = RDCAP;
      RDCAP: begin
        state_d = IDLE;
        rsp_d   = 1'b1;
        rdata_d = hdata_in;
      end
      default: state_d = BOOT0;
    endcase
  end

  // state and output registers; BOOT0 is held with started_q low until the first edge after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT0;
      started_q <= 1'b0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      hen_q     <= 1'b0;
      hwr_q     <= 1'b0;
      oe_q      <= 1'b0;
      rsp_q     <= 1'b0;
      done_q    <= 1'b0;
      haddr_q   <= 16'h0000;
      hdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      last_q    <= last_d;
      id_q      <= id_d;
      hen_q     <= hen_d;
      hwr_q     <= hwr_d;
      oe_q      <= oe_d;
      rsp_q     <= rsp_d;
      done_q    <= done_d;
      haddr_q   <= haddr_d;
      hdata_q   <= hdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp_q & ~id_q;
  assign rsp1_valid = rsp_q & id_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
  assign haddr      = haddr_q;
  assign hdata_out  = hdata_q;
  assign hdata_oe   = oe_q;
  assign hen        = hen_q;
  assign hwr_rd     = hwr_q;
  assign boot_done  = done_q;
endmodule

// File: tb/tb_router_cfg_ctrl.sv
// tb_router_cfg_ctrl: random two-requester traffic against a cycle-count reference model and scoreboard
module tb_router_cfg_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_wr = 1'b0, req1_valid = 1'b0, req1_wr = 1'b0;
  logic [15:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_rdata, rsp1_rdata, hdata_out;
  logic [7:0]  hdata_in = '0;
  logic [15:0] haddr;
  logic        hdata_oe, hen, hwr_rd, boot_done;

  typedef struct {int c; logic wr; logic [15:0] a; logic [7:0] d;} bus_t;
  typedef struct {int c; logic id; logic [7:0] d;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] rmem [logic [15:0]];
  int total = 0, bad = 0, cyc = 0, rel = 0, next_idle = 0, last_acc = -1;
  logic in_rst = 1'b1, last = 1'b1, rd_pend = 1'b0;
  logic [7:0] rd_val = '0;

  router_cfg_ctrl dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .haddr(haddr), .hdata_out(hdata_out), .hdata_oe(hdata_oe), .hdata_in(hdata_in),
    .hen(hen), .hwr_rd(hwr_rd), .boot_done(boot_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    int r = $urandom_range(0, 9);
    return r < 2 ? 16'h1000 + 16'(r) : 16'(r - 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // router register file: writes land on hen, read data is garbage except during the capture cycle
  always @(negedge clock) begin
    hdata_in = rd_pend ? rd_val : 8'($urandom);
    rd_pend  = 1'b0;
    if (reset && hen) begin
      if (hwr_rd) rmem[haddr] = hdata_out;
      else begin
        rd_pend = 1'b1;
        rd_val  = rmem.exists(haddr) ? rmem[haddr] : dflt(haddr);
      end
    end
  end

  // monitor: pops expected bus cycles and responses as the DUT presents them
  always @(negedge clock) begin
    bus_t b;
    rsp_t r;
    if (reset) begin
      while (bus_q.size() > 0 && bus_q[0].c < cyc) begin
        chk("hen_missing", bus_q[0].c, cyc);
        void'(bus_q.pop_front());
      end
      while (rsp_q.size() > 0 && rsp_q[0].c < cyc) begin
        chk("rsp_missing", rsp_q[0].c, cyc);
        void'(rsp_q.pop_front());
      end
      if (hen) begin
        if (bus_q.size() == 0) chk("hen_unexpected", bus_q.size(), 1);
        else begin
          b = bus_q.pop_front();
          chk("hen_cycle", cyc, b.c);
          chk("hwr_rd", hwr_rd, b.wr);
          chk("hdata_oe", hdata_oe, b.wr);
          chk("haddr", haddr, b.a);
          if (b.wr) chk("hdata_out", hdata_out, b.d);
        end
      end else chk("idle_ctl", {hwr_rd, hdata_oe}, 0);
      chk("rsp_overlap", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid | rsp1_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_q.size(), 1);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_cycle", cyc, r.c);
          chk("rsp_id", rsp1_valid, r.id);
          chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, r.d);
        end
      end
    end
  end

  task automatic step(input logic rv, input logic v0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                      input logic v1, input logic w1, input logic [15:0] a1, input logic [7:0] d1);
    logic idle, g0, g1, wr;
    logic [15:0] a;
    logic [7:0] d, rd;
    @(negedge clock);
    if (rv && in_rst) begin
      rel = cyc;
      next_idle = cyc + 3;
      bus_q.push_back('{cyc + 1, 1'b1, 16'h1000, 8'h3F});
      bus_q.push_back('{cyc + 2, 1'b1, 16'h1001, 8'h01});
      ref_mem[16'h1000] = 8'h3F;
      ref_mem[16'h1001] = 8'h01;
    end
    reset = rv;
    in_rst = !rv;
    if (in_rst) last = 1'b1;
    req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    idle = !in_rst && cyc >= next_idle;
    g0 = idle && v0 && (!v1 || last);
    g1 = idle && v1 && (!v0 || !last);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("boot_done", boot_done, !in_rst && cyc >= rel + 3);
    if (in_rst) begin
      chk("rst_bus", {hen, hwr_rd, hdata_oe, haddr, hdata_out}, 0);
      chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 0);
    end
    last_acc = -1;
    if (g0 || g1) begin
      wr = g1 ? w1 : w0;
      a  = g1 ? a1 : a0;
      d  = g1 ? d1 : d0;
      rd = wr ? 8'h00 : ref_rd(a);
      if (wr) ref_mem[a] = d;
      bus_q.push_back('{cyc + 1, wr, a, d});
      rsp_q.push_back('{cyc + (wr ? 2 : 3), g1, rd});
      next_idle = cyc + (wr ? 2 : 3);
      last = g1;
      last_acc = g1 ? 1 : 0;
    end
  endtask

  task automatic idle_step(input logic rv);
    step(rv, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
  endtask

  task automatic rnd_step(input int pv, input logic both_wr);
    step(1'b1, $urandom_range(0, 99) < pv, both_wr | 1'($urandom), rnd_addr(), 8'($urandom),
         $urandom_range(0, 99) < pv, both_wr | 1'($urandom), rnd_addr(), 8'($urandom));
  endtask

  task automatic rst_mid();
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #3;
    reset = 1'b0;
    in_rst = 1'b1;
    last = 1'b1;
    #1;
    chk("mid_rst_bus", {hen, hwr_rd, hdata_oe, haddr}, 0);
    chk("mid_rst_rsp", {rsp0_valid, rsp1_valid, boot_done}, 0);
    bus_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) idle_step(0);
    step(1, 1, 1, 16'h0005, 8'hA5, 0, 0, 16'h0, 8'h0);
    for (int i = 0; i < 10 && last_acc != 0; i++) step(1, 1, 1, 16'h0005, 8'hA5, 0, 0, 16'h0, 8'h0);
    chk("boot_held_accept", last_acc, 0);
    repeat (3) idle_step(1);
    step(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h1000, 8'h0);
    repeat (4) idle_step(1);
    repeat (12) rnd_step(100, 1'b1);
    repeat (4) idle_step(1);
    repeat (300) rnd_step(60, 1'b0);
    repeat (4) idle_step(1);
    step(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0003, 8'h0);
    rst_mid();
    repeat (2) idle_step(0);
    idle_step(1);
    repeat (100) rnd_step(60, 1'b0);
    repeat (8) idle_step(1);
    chk("bus_q_left", bus_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_cfg_ctrl.md
ROUTER_CFG_CTRL -- requirements
Module: router_cfg_ctrl

Interface
REQ-001 Parameter BOOT_MAXPKT, default 8'd63, value written to the router max-packet-size register at boot.
REQ-002 Parameter BOOT_ENABLE, default 8'd1, value written to the router enable register at boot.
REQ-003 Parameter ADDR_MAXPKT, default 16'h1000, HBUS address of the max-packet-size register.
REQ-004 Parameter ADDR_ENABLE, default 16'h1001, HBUS address of the router enable register.
REQ-005 clock  input  1  the single clock; all flops rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 reqN_valid  input  1  (N=0,1) requester N has an HBUS command.
REQ-008 reqN_wr  input  1  1 = write, 0 = read.
REQ-009 reqN_addr  input  16  register address.
REQ-010 reqN_wdata  input  8  write data.
REQ-011 reqN_ready  output  1  command accepted this cycle when valid&ready.
REQ-012 rspN_valid  output  1  one-cycle completion pulse for requester N.
REQ-013 rspN_rdata  output  8  read data, valid with rspN_valid; 0 for writes.
REQ-014 haddr  output  16  HBUS address.
REQ-015 hdata_out  output  8  HBUS write data.
REQ-016 hdata_oe  output  1  drive enable for hdata_out (write cycles only).
REQ-017 hdata_in  input  8  HBUS read data from router.
REQ-018 hen  output  1  HBUS enable, one-cycle pulse per transaction.
REQ-019 hwr_rd  output  1  1 = write, 0 = read; meaningful only with hen=1.
REQ-020 boot_done  output  1  high once boot writes completed; stays high until reset.

Function
REQ-021 FSM states SHALL be BOOT0, BOOT1, IDLE, WR, RD, RDCAP.
REQ-022 After reset release SHALL enter BOOT0: hen=1, hwr_rd=1, hdata_oe=1, haddr=ADDR_MAXPKT, hdata_out=BOOT_MAXPKT, for exactly one cycle.
REQ-023 BOOT1 next cycle: same with ADDR_ENABLE/BOOT_ENABLE; then IDLE, boot_done=1 from the first IDLE cycle.
REQ-024 reqN_ready SHALL be 0 in every state except IDLE; in IDLE only the granted requester's ready is 1, combinationally from valids.
REQ-025 Arbitration in IDLE: only one valid -> grant it; both valid -> grant the one not granted last; last-grant flop resets to 1 (req0 wins first tie).
REQ-026 On accept, addr/wdata/wr/requester id SHALL be registered; next state WR if wr=1 else RD.
REQ-027 WR: one cycle hen=1, hwr_rd=1, hdata_oe=1, registered addr/data; then IDLE with rspN_valid=1, rspN_rdata=0 in that IDLE cycle.
REQ-028 RD: one cycle hen=1, hwr_rd=0, hdata_oe=0; RDCAP: hen=0, hdata_in sampled into rspN_rdata; next cycle IDLE with rspN_valid=1.
REQ-029 Completion pulse in IDLE SHALL NOT block a new accept in that same cycle; write throughput one per 2 cycles, read one per 3.
REQ-030 Outside BOOT0/BOOT1/WR/RD, hen=0, hdata_oe=0, hwr_rd=0; haddr/hdata_out hold last value.
REQ-031 reqN_* inputs SHALL be ignored while not ready; valid dropped before acceptance is legal and loses nothing.
REQ-032 At most one transaction outstanding; rsp0_valid and rsp1_valid never high together.

Reset
REQ-033 reset=0 SHALL immediately force: state BOOT0-pending (held), hen=0, hwr_rd=0, hdata_oe=0, haddr=0, hdata_out=0, all ready=0, all rsp_valid=0, rspN_rdata=0, boot_done=0, last-grant=1.
REQ-034 Reset mid-transaction SHALL drop the transaction with no response; boot sequence re-runs after release.

Verification
REQ-035 Release reset -> cycle 1 hen=1 haddr=0x1000 hdata_out=0x3F hwr_rd=1; cycle 2 haddr=0x1001 hdata_out=0x01; cycle 3 boot_done=1.
REQ-036 req0 write addr 0x0005 data 0xA5 in IDLE -> next cycle hen=1 hwr_rd=1 haddr=0x0005 hdata_out=0xA5; following cycle rsp0_valid=1 rdata=0.
REQ-037 req1 read 0x1000, hdata_in=0x3F during RDCAP -> hen=1 hwr_rd=0 once, rsp1_valid=1 rsp1_rdata=0x3F two cycles after hen.
REQ-038 req0 and req1 both valid continuously with writes -> grants alternate 0,1,0,1; no rsp overlap; hen every 2nd cycle.
REQ-039 Assert reset during RD cycle -> hen drops immediately, no rsp1_valid; after release boot writes 0x1000/0x1001 repeat.
REQ-040 req0_valid asserted during boot -> req0_ready=0 until first IDLE cycle, then accepted there.
